// File: rtl/bp_pkg.sv
// Shared branch-predictor types: BTB geometry defaults, counter encoding,
// update-entry layout and the resolution FSM states.
package bp_pkg;

    localparam int unsigned BP_INDEX_W = 5;
    localparam int unsigned BP_TAG_W   = 27;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } counter_t;

    typedef struct packed {
        logic [BP_INDEX_W-1:0] index;
        logic [BP_TAG_W-1:0]   tag;
        logic [31:0]           target;
        counter_t              counter;
    } btb_upd_t;

    typedef enum logic {
        IDLE,
        RECOVER
    } bru_state_t;

    // 2-bit saturating update; a disabled predictor always writes strongly-not-taken.
    function automatic counter_t next_counter(input logic [1:0] old,
                                              input logic       taken,
                                              input logic       disable_bp);
        counter_t n;
        if (disable_bp) begin
            n = SNT;
        end else if (taken) begin
            n = (old == 2'd3) ? ST : counter_t'(old + 2'd1);
        end else begin
            n = (old == 2'd0) ? SNT : counter_t'(old - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO of BTB update entries; power-of-two DEPTH, pointers wrap naturally.
// Pushes while full and pops while empty are dropped.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = btb_upd_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Storage is not reset, so the head is forced to zero while empty.
    assign rdata = empty ? entry_t'('0) : mem[rd_ptr];

endmodule

// File: rtl/branch_resolution_unit.sv
// EX-stage branch resolution: detects mispredictions, drives a registered
// redirect/flush and queues BTB updates. Optional stats under BRANCH_STATS_EN.
module branch_resolution_unit
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INDEX_W = BP_INDEX_W,
    parameter int unsigned TAG_W   = BP_TAG_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_e_i,
    input  logic [31:0]        pc_e_i,
    input  logic [31:0]        target_e_i,
    input  logic               taken_e_i,
    input  logic               pred_taken_e_i,
    input  logic [31:0]        pred_target_e_i,
    input  logic [1:0]         old_counter_e_i,
    input  logic               disable_bp_i,
    input  logic               btb_ready_i,
    output logic               stall_e_o,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o,
    output logic               flush_o,
    output logic               btb_we_o,
    output logic [INDEX_W-1:0] btb_index_o,
    output logic [TAG_W-1:0]   btb_tag_o,
    output logic [31:0]        btb_target_o,
`ifdef BRANCH_STATS_EN
    output logic [31:0]        branch_count_o,
    output logic [31:0]        mispredict_count_o,
`endif
    output logic [1:0]         btb_counter_o
);

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [TAG_W-1:0]   tag;
        logic [31:0]        target;
        counter_t           counter;
    } upd_t;

    bru_state_t  state_q;
    bru_state_t  state_d;
    logic        acc;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    upd_t        push_entry;
    upd_t        head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    always_comb begin
        acc        = valid_e_i & ~fifo_full & (state_q == IDLE);
        mispredict = acc & ((pred_taken_e_i != taken_e_i) |
                            (taken_e_i & pred_taken_e_i & (pred_target_e_i != target_e_i)));
        correct_pc = taken_e_i ? target_e_i : (pc_e_i + 32'd4);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mispredict) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect PC is cleared outside the redirect cycle so fetch never sees a stale target.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q    <= mispredict;
            redirect_pc_q <= mispredict ? correct_pc : '0;
        end
    end

    assign redirect_o    = redirect_q;
    assign flush_o       = redirect_q;
    assign redirect_pc_o = redirect_pc_q;

    always_comb begin
        push_entry.index   = pc_e_i[INDEX_W-1:0];
        push_entry.tag     = pc_e_i[31:INDEX_W];
        push_entry.target  = target_e_i;
        push_entry.counter = next_counter(old_counter_e_i, taken_e_i, disable_bp_i);
    end

    assign fifo_pop = ~fifo_empty & btb_ready_i;

    bp_update_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (upd_t)
    ) u_update_fifo (
        .clk   (clk_i),
        .rst_n (reset_i),
        .push  (acc),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign stall_e_o     = fifo_full;
    assign btb_we_o      = ~fifo_empty;
    assign btb_index_o   = head.index;
    assign btb_tag_o     = head.tag;
    assign btb_target_o  = head.target;
    assign btb_counter_o = head.counter;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            branch_count_o     <= '0;
            mispredict_count_o <= '0;
        end else begin
            if (acc) begin
                branch_count_o <= branch_count_o + 32'd1;
            end
            if (mispredict) begin
                mispredict_count_o <= mispredict_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: directed cases plus random
// traffic against a queue-based reference model.
module tb_branch_resolution_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk_i;
    logic        reset_i;
    logic        valid_e_i;
    logic [31:0] pc_e_i;
    logic [31:0] target_e_i;
    logic        taken_e_i;
    logic        pred_taken_e_i;
    logic [31:0] pred_target_e_i;
    logic [1:0]  old_counter_e_i;
    logic        disable_bp_i;
    logic        btb_ready_i;
    logic        stall_e_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        btb_we_o;
    logic [4:0]  btb_index_o;
    logic [26:0] btb_tag_o;
    logic [31:0] btb_target_o;
    logic [1:0]  btb_counter_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_o;
    logic [31:0] mispredict_count_o;
`endif

    branch_resolution_unit #(
        .DEPTH   (DEPTH),
        .INDEX_W (5),
        .TAG_W   (27)
    ) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .valid_e_i          (valid_e_i),
        .pc_e_i             (pc_e_i),
        .target_e_i         (target_e_i),
        .taken_e_i          (taken_e_i),
        .pred_taken_e_i     (pred_taken_e_i),
        .pred_target_e_i    (pred_target_e_i),
        .old_counter_e_i    (old_counter_e_i),
        .disable_bp_i       (disable_bp_i),
        .btb_ready_i        (btb_ready_i),
        .stall_e_o          (stall_e_o),
        .redirect_o         (redirect_o),
        .redirect_pc_o      (redirect_pc_o),
        .flush_o            (flush_o),
        .btb_we_o           (btb_we_o),
        .btb_index_o        (btb_index_o),
        .btb_tag_o          (btb_tag_o),
        .btb_target_o       (btb_target_o),
`ifdef BRANCH_STATS_EN
        .branch_count_o     (branch_count_o),
        .mispredict_count_o (mispredict_count_o),
`endif
        .btb_counter_o      (btb_counter_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          tk;
        bit          pt;
        logic [31:0] ptgt;
        int unsigned old;
        bit          dis;
        bit          rdy;
    } stim_t;

    typedef struct {
        int unsigned index;
        int unsigned tag;
        logic [31:0] target;
        int unsigned counter;
    } exp_t;

    exp_t        exp_q[$];
    bit          exp_recover;
    bit          exp_redirect;
    logic [31:0] exp_redirect_pc;
    logic [31:0] exp_branch_cnt;
    logic [31:0] exp_mis_cnt;

    int unsigned n_compared;
    int unsigned n_mismatched;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t mk(bit v, logic [31:0] pc, logic [31:0] tgt, bit tk, bit pt,
                                 logic [31:0] ptgt, int unsigned old, bit dis, bit rdy);
        stim_t s;
        s.v = v; s.pc = pc; s.tgt = tgt; s.tk = tk; s.pt = pt;
        s.ptgt = ptgt; s.old = old; s.dis = dis; s.rdy = rdy;
        return s;
    endfunction

    task automatic check_outputs();
        check_eq("redirect", {31'd0, redirect_o}, {31'd0, exp_redirect});
        check_eq("flush", {31'd0, flush_o}, {31'd0, exp_redirect});
        check_eq("redirect_pc", redirect_pc_o, exp_redirect_pc);
        check_eq("stall", {31'd0, stall_e_o}, (exp_q.size() == DEPTH) ? 32'd1 : 32'd0);
        check_eq("btb_we", {31'd0, btb_we_o}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
        if (exp_q.size() != 0) begin
            check_eq("btb_index", {27'd0, btb_index_o}, exp_q[0].index);
            check_eq("btb_tag", {5'd0, btb_tag_o}, exp_q[0].tag);
            check_eq("btb_target", btb_target_o, exp_q[0].target);
            check_eq("btb_counter", {30'd0, btb_counter_o}, exp_q[0].counter);
        end else begin
            check_eq("btb_fields_idle",
                     {27'd0, btb_index_o} | {5'd0, btb_tag_o} | btb_target_o | {30'd0, btb_counter_o},
                     32'd0);
        end
`ifdef BRANCH_STATS_EN
        check_eq("branch_count", branch_count_o, exp_branch_cnt);
        check_eq("mispredict_count", mispredict_count_o, exp_mis_cnt);
`endif
    endtask

    // Model of one clock edge: decide acceptance from the pre-edge view, then update.
    task automatic model_edge(input stim_t s);
        bit   full;
        bit   acc;
        bit   mis;
        int   c;
        exp_t e;
        full = (exp_q.size() == DEPTH);
        acc  = s.v && !full && !exp_recover;
        mis  = acc && ((s.pt != s.tk) || (s.tk && s.pt && (s.ptgt != s.tgt)));
        if (exp_q.size() != 0 && s.rdy) void'(exp_q.pop_front());
        if (acc) begin
            c = int'(s.old);
            c = s.tk ? ((c + 1 > 3) ? 3 : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
            if (s.dis) c = 0;
            e.index   = s.pc % 32;
            e.tag     = s.pc / 32;
            e.target  = s.tgt;
            e.counter = c;
            exp_q.push_back(e);
            exp_branch_cnt = exp_branch_cnt + 1;
        end
        if (mis) exp_mis_cnt = exp_mis_cnt + 1;
        exp_redirect    = mis;
        exp_redirect_pc = mis ? (s.tk ? s.tgt : s.pc + 32'd4) : 32'd0;
        exp_recover     = mis;
    endtask

    // Called at posedge+1; drives, advances one edge, checks at the next posedge+1.
    task automatic step(input stim_t s);
        valid_e_i       = s.v;
        pc_e_i          = s.pc;
        target_e_i      = s.tgt;
        taken_e_i       = s.tk;
        pred_taken_e_i  = s.pt;
        pred_target_e_i = s.ptgt;
        old_counter_e_i = s.old[1:0];
        disable_bp_i    = s.dis;
        btb_ready_i     = s.rdy;
        model_edge(s);
        @(posedge clk_i);
        #1;
        check_outputs();
    endtask

    task automatic drain(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_recover     = 0;
        exp_redirect    = 0;
        exp_redirect_pc = '0;
        exp_branch_cnt  = '0;
        exp_mis_cnt     = '0;
    endtask

    task automatic apply_reset();
        valid_e_i   = 0;
        btb_ready_i = 0;
        reset_i     = 0;
        #2;
        check_eq("rst_async_btb_we", {31'd0, btb_we_o}, 32'd0);
        check_eq("rst_async_redirect", {31'd0, redirect_o}, 32'd0);
        model_clear();
        @(posedge clk_i);
        #1;
        reset_i = 1;
        check_outputs();
    endtask

    initial begin
        stim_t s;
        logic [31:0] r;
        n_compared   = 0;
        n_mismatched = 0;
        model_clear();
        reset_i = 0; valid_e_i = 0; pc_e_i = '0; target_e_i = '0; taken_e_i = 0;
        pred_taken_e_i = 0; pred_target_e_i = '0; old_counter_e_i = '0;
        disable_bp_i = 0; btb_ready_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs();
        reset_i = 1;
        drain(2);

        // Direction mispredict, then a wrong-path valid in the recover cycle.
        step(mk(1, 32'h100, 32'h200, 1, 0, 32'h0, 1, 0, 0));
        check_eq("tp1_redirect", {31'd0, redirect_o}, 32'd1);
        check_eq("tp1_redirect_pc", redirect_pc_o, 32'h200);
        step(mk(1, 32'h180, 32'h500, 1, 0, 32'h0, 0, 0, 0));
        check_eq("tp1_one_cycle", {31'd0, redirect_o}, 32'd0);
        check_eq("tp1_index", {27'd0, btb_index_o}, 32'h0);
        check_eq("tp1_tag", {5'd0, btb_tag_o}, 32'h8);
        check_eq("tp1_counter", {30'd0, btb_counter_o}, 32'd2);
        drain(2);

        // Correct predictions with counters saturating at both ends.
        step(mk(1, 32'h104, 32'h0, 0, 0, 32'h0, 0, 0, 0));
        check_eq("tp2_no_redirect", {31'd0, redirect_o}, 32'd0);
        check_eq("tp2_ctr_sat_lo", {30'd0, btb_counter_o}, 32'd0);
        step(mk(1, 32'h108, 32'h400, 1, 1, 32'h400, 3, 0, 0));
        drain(1);
        check_eq("tp2_ctr_sat_hi", {30'd0, btb_counter_o}, 32'd3);
        drain(2);

        // Target mismatch on a correctly predicted taken branch.
        step(mk(1, 32'h120, 32'h340, 1, 1, 32'h300, 2, 0, 1));
        check_eq("tp3_redirect_pc", redirect_pc_o, 32'h340);
        drain(2);

        // Not-taken fall-through wraps past the top of the address space.
        step(mk(1, 32'hFFFF_FFFC, 32'h10, 0, 1, 32'h10, 2, 0, 1));
        check_eq("wrap_redirect_pc", redirect_pc_o, 32'h0);
        drain(2);

        // Fill the FIFO, hold a fifth branch, then drain in order.
        for (int unsigned i = 0; i < DEPTH; i++)
            step(mk(1, 32'h200 + 32'(4 * i), 32'h600 + 32'(i), 0, 0, 32'h0, 1, 0, 0));
        check_eq("fill_stall", {31'd0, stall_e_o}, 32'd1);
        step(mk(1, 32'h300, 32'h700, 1, 1, 32'h700, 1, 0, 0));
        check_eq("held_stall", {31'd0, stall_e_o}, 32'd1);
        step(mk(1, 32'h300, 32'h700, 1, 1, 32'h700, 1, 0, 1));
        check_eq("stall_drop", {31'd0, stall_e_o}, 32'd0);
        step(mk(1, 32'h300, 32'h700, 1, 1, 32'h700, 1, 0, 1));
        drain(6);

        // Disabled predictor writes a zero counter.
        step(mk(1, 32'h44, 32'h80, 1, 1, 32'h80, 2, 1, 0));
        check_eq("disable_ctr", {30'd0, btb_counter_o}, 32'd0);
        drain(2);

        // Reset with entries queued and a redirect in flight.
        step(mk(1, 32'h500, 32'h0, 0, 0, 32'h0, 1, 0, 0));
        step(mk(1, 32'h504, 32'h0, 0, 0, 32'h0, 1, 0, 0));
        step(mk(1, 32'h508, 32'h900, 1, 0, 32'h0, 1, 0, 0));
        apply_reset();
        drain(4);

        // Random traffic.
        for (int unsigned i = 0; i < 400; i++) begin
            r = $urandom;
            s.v    = ($urandom_range(0, 9) < 7);
            s.pc   = (r[3:0] == 4'hF) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            s.tgt  = $urandom & 32'hFFFF_FFFC;
            s.tk   = r[4];
            s.pt   = (r[7:5] == 3'd0) ? ~r[4] : r[4];
            s.ptgt = (r[10:8] == 3'd0) ? (s.tgt ^ 32'h40) : s.tgt;
            s.old  = $urandom_range(0, 3);
            s.dis  = (r[14:11] == 4'd0);
            s.rdy  = r[15];
            step(s);
        end
        drain(DEPTH + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
